// File: rtl/hazard_track_pkg.sv
// Shared constants and slot layout for the MEM/WB destination tracker.
// Holds register-index width, slot layout, zero-register and forwarding codes.
package hazard_track_pkg;

    localparam int REG_AW_DEF = 5;

    // Slot layout, MSB first: {rd, regwrite, memread, valid}
    typedef struct packed {
        logic [REG_AW_DEF-1:0] rd;
        logic                  regwrite;
        logic                  memread;
        logic                  valid;
    } slot_t;

    localparam int SLOT_W      = REG_AW_DEF + 3;
    localparam int SLOT_VALID  = 0;
    localparam int SLOT_MEMRD  = 1;
    localparam int SLOT_REGWR  = 2;
    localparam int SLOT_RD_LSB = 3;

    localparam int ZERO_REG = 0;

    // Forwarding source select encodings
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_slot.sv
// One pipeline slot register (load / bubble / hold) for rd tracking.
// Ports: clk, rst_n, i_load, i_bubble, i_rd/regwrite/memread/valid in, o_* out.
module hazard_slot
    import hazard_track_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_bubble,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_regwrite,
    input  logic              i_memread,
    input  logic              i_valid,
    output logic [REG_AW-1:0] o_rd,
    output logic              o_regwrite,
    output logic              o_memread,
    output logic              o_valid
);

    logic [REG_AW-1:0] r_rd;
    logic              r_regwrite;
    logic              r_memread;
    logic              r_valid;

    logic              w_rd_nz;

    // A write to x0 is architecturally dead, so never advertise it
    assign w_rd_nz = (i_rd != REG_AW'(ZERO_REG));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_valid    <= 1'b0;
        end else if (i_load) begin
            // Store already-qualified fields so a bubble reads as all zero
            r_rd       <= i_valid ? i_rd : '0;
            r_regwrite <= i_valid & i_regwrite & w_rd_nz;
            r_memread  <= i_valid & i_memread;
            r_valid    <= i_valid;
        end else if (i_bubble) begin
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_valid    <= 1'b0;
        end
    end

    assign o_rd       = r_rd;
    assign o_regwrite = r_regwrite;
    assign o_memread  = r_memread;
    assign o_valid    = r_valid;

endmodule

// File: rtl/hazard_track.sv
// MEM/WB destination tracker and load-use hazard detector.
// Optional counters: define HAZARD_TRACK_STALL_CNT_EN for stall_cnt/memstall_cnt.
module hazard_track
    import hazard_track_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ID_valid,
    input  logic [REG_AW-1:0] ID_rs1,
    input  logic [REG_AW-1:0] ID_rs2,
    input  logic              EX_valid,
    input  logic [REG_AW-1:0] EX_rd,
    input  logic              EX_regwrite,
    input  logic              EX_memread,
    input  logic              flush_ex,
    input  logic              mem_stall,
    output logic [REG_AW-1:0] MEM_rd,
    output logic              MEM_regwrite,
    output logic              MEM_memread,
    output logic [REG_AW-1:0] WB_rd,
    output logic              WB_regwrite,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       memstall_cnt
);

    logic              r_pend_flush;
    logic              w_flush_eff;
    logic              w_adv;
    logic              w_hz;

    logic [REG_AW-1:0] w_mem_rd;
    logic              w_mem_rw;
    logic              w_mem_mr;
    logic              w_mem_v;
    logic [REG_AW-1:0] w_wb_rd;
    logic              w_wb_rw;
    logic              w_wb_mr;
    logic              w_wb_v;

    // A flush seen while MEM is frozen must still kill the EX
    // instruction that enters MEM on release
    assign w_flush_eff = flush_ex | r_pend_flush;
    assign w_adv       = ~mem_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_flush <= 1'b0;
        end else if (w_adv) begin
            r_pend_flush <= 1'b0;
        end else if (flush_ex) begin
            r_pend_flush <= 1'b1;
        end
    end

    hazard_slot #(.REG_AW(REG_AW)) u_mem (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_adv),
        .i_bubble   (1'b0),
        .i_rd       (EX_rd),
        .i_regwrite (EX_regwrite),
        .i_memread  (EX_memread),
        .i_valid    (EX_valid & ~w_flush_eff),
        .o_rd       (w_mem_rd),
        .o_regwrite (w_mem_rw),
        .o_memread  (w_mem_mr),
        .o_valid    (w_mem_v)
    );

    // WB takes a bubble while MEM is frozen so the retiring write
    // is presented exactly once
    hazard_slot #(.REG_AW(REG_AW)) u_wb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_adv),
        .i_bubble   (mem_stall),
        .i_rd       (w_mem_rd),
        .i_regwrite (w_mem_rw),
        .i_memread  (w_mem_mr),
        .i_valid    (w_mem_v),
        .o_rd       (w_wb_rd),
        .o_regwrite (w_wb_rw),
        .o_memread  (w_wb_mr),
        .o_valid    (w_wb_v)
    );

    assign MEM_rd       = w_mem_rd;
    assign MEM_regwrite = w_mem_v & w_mem_rw;
    assign MEM_memread  = w_mem_v & w_mem_mr;
    assign WB_rd        = w_wb_rd;
    assign WB_regwrite  = w_wb_v & w_wb_rw & ~w_wb_mr | w_wb_v & w_wb_rw & w_wb_mr;

    assign w_hz = EX_valid & EX_memread & EX_regwrite
                & (EX_rd != REG_AW'(ZERO_REG))
                & ID_valid
                & ((EX_rd == ID_rs1) | (EX_rd == ID_rs2));

    // A taken branch kills the consumer, so no stall is needed
    assign stall_id  = w_hz & ~flush_ex;
    assign bubble_ex = w_hz & ~flush_ex;

`ifdef HAZARD_TRACK_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_memstall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt    <= '0;
            r_memstall_cnt <= '0;
        end else begin
            if (stall_id) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (mem_stall) begin
                r_memstall_cnt <= r_memstall_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt    = r_stall_cnt;
    assign memstall_cnt = r_memstall_cnt;
`else
    assign stall_cnt    = 32'd0;
    assign memstall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_track.sv
// Self-checking bench for hazard_track: directed plan plus random traffic
// compared each cycle against an instruction-level reference model.
module tb_hazard_track;

    logic        clk;
    logic        rst_n;
    logic        ID_valid;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic        EX_valid;
    logic [4:0]  EX_rd;
    logic        EX_regwrite;
    logic        EX_memread;
    logic        flush_ex;
    logic        mem_stall;
    logic [4:0]  MEM_rd;
    logic        MEM_regwrite;
    logic        MEM_memread;
    logic [4:0]  WB_rd;
    logic        WB_regwrite;
    logic        stall_id;
    logic        bubble_ex;
    logic [31:0] stall_cnt;
    logic [31:0] memstall_cnt;

    int total = 0;
    int bad   = 0;

`ifdef HAZARD_TRACK_STALL_CNT_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    hazard_track dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ID_valid     (ID_valid),
        .ID_rs1       (ID_rs1),
        .ID_rs2       (ID_rs2),
        .EX_valid     (EX_valid),
        .EX_rd        (EX_rd),
        .EX_regwrite  (EX_regwrite),
        .EX_memread   (EX_memread),
        .flush_ex     (flush_ex),
        .mem_stall    (mem_stall),
        .MEM_rd       (MEM_rd),
        .MEM_regwrite (MEM_regwrite),
        .MEM_memread  (MEM_memread),
        .WB_rd        (WB_rd),
        .WB_regwrite  (WB_regwrite),
        .stall_id     (stall_id),
        .bubble_ex    (bubble_ex),
        .stall_cnt    (stall_cnt),
        .memstall_cnt (memstall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What the forwarding unit should see for one instruction in a slot
    typedef struct packed {
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } view_t;

    view_t       m_mem;
    view_t       m_wb;
    logic        m_pend;
    logic [31:0] m_sc;
    logic [31:0] m_mc;

    function automatic logic exp_stall();
        logic dep;
        dep = (EX_rd == ID_rs1) || (EX_rd == ID_rs2);
        return EX_valid && EX_memread && EX_regwrite && EX_rd != 0
               && ID_valid && dep && !flush_ex;
    endfunction

    function automatic view_t ex_view(input logic alive);
        view_t v;
        v = '0;
        if (alive) begin
            v.rd = EX_rd;
            v.rw = EX_regwrite && (EX_rd != 0);
            v.mr = EX_memread;
        end
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mem  <= '0;
            m_wb   <= '0;
            m_pend <= 1'b0;
            m_sc   <= '0;
            m_mc   <= '0;
        end else begin
            if (!mem_stall) begin
                m_mem  <= ex_view(EX_valid && !(flush_ex || m_pend));
                m_wb   <= m_mem;
                m_pend <= 1'b0;
            end else begin
                m_wb <= '0;
                if (flush_ex) m_pend <= 1'b1;
            end
            if (exp_stall()) m_sc <= m_sc + 32'd1;
            if (mem_stall)   m_mc <= m_mc + 32'd1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_mem_rd", 32'(MEM_rd), 32'(m_mem.rd));
        chk("cmp_mem_rw", 32'(MEM_regwrite), 32'(m_mem.rw));
        chk("cmp_mem_mr", 32'(MEM_memread), 32'(m_mem.mr));
        chk("cmp_wb_rd", 32'(WB_rd), 32'(m_wb.rd));
        chk("cmp_wb_rw", 32'(WB_regwrite), 32'(m_wb.rw));
        chk("cmp_stall", 32'(stall_id), 32'(exp_stall()));
        chk("cmp_bubble", 32'(bubble_ex), 32'(exp_stall()));
        chk("cmp_scnt", stall_cnt, FEAT ? m_sc : 32'd0);
        chk("cmp_mcnt", memstall_cnt, FEAT ? m_mc : 32'd0);
    end

    task automatic set_in(input logic ev, input logic [4:0] rd,
                          input logic rw, input logic mr,
                          input logic idv, input logic [4:0] r1,
                          input logic [4:0] r2, input logic fl,
                          input logic ms);
        EX_valid    = ev;
        EX_rd       = rd;
        EX_regwrite = rw;
        EX_memread  = mr;
        ID_valid    = idv;
        ID_rs1      = r1;
        ID_rs2      = r2;
        flush_ex    = fl;
        mem_stall   = ms;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #12 rst_n = 1'b1;
        tick();
        chk("rst_mem_rd", 32'(MEM_rd), 0);
        chk("rst_wb_rw", 32'(WB_regwrite), 0);

        // 1: async reset with a pending flush
        set_in(1, 4, 1, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(1, 6, 1, 0, 0, 0, 0, 1, 1);
        tick();
        chk("t1_mem_before", 32'(MEM_rd), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_rd", 32'(MEM_rd), 0);
        chk("t1_async_rw", 32'(MEM_regwrite), 0);
        chk("t1_async_wb", 32'(WB_rd), 0);
        #2 rst_n = 1'b1;
        set_in(1, 3, 1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("t1_first_rd", 32'(MEM_rd), 3);
        chk("t1_first_rw", 32'(MEM_regwrite), 1);

        // 2: load-use on rs2
        set_in(1, 5, 1, 1, 1, 2, 5, 0, 0);
        #1;
        chk("t2_stall", 32'(stall_id), 1);
        chk("t2_bubble", 32'(bubble_ex), 1);
        tick();
        set_in(0, 0, 0, 0, 1, 2, 5, 0, 0);
        #1;
        chk("t2_stall_off", 32'(stall_id), 0);
        chk("t2_mem_rd", 32'(MEM_rd), 5);
        chk("t2_mem_mr", 32'(MEM_memread), 1);
        set_in(1, 5, 1, 1, 1, 5, 0, 1, 0);
        #1;
        chk("t2_flush_kill", 32'(stall_id), 0);
        tick();

        // 3: rd = x0
        set_in(1, 0, 1, 1, 1, 0, 3, 0, 0);
        #1;
        chk("t3_stall", 32'(stall_id), 0);
        tick();
        chk("t3_mem_rw", 32'(MEM_regwrite), 0);

        // 4: mem_stall holds MEM, WB retires once
        set_in(1, 7, 1, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(1, 8, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold_rd", 32'(MEM_rd), 7);
            chk("t4_hold_rw", 32'(MEM_regwrite), 1);
            chk("t4_wb_quiet", 32'(WB_regwrite), 0);
        end
        set_in(1, 8, 1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("t4_wb_rw", 32'(WB_regwrite), 1);
        chk("t4_wb_rd", 32'(WB_rd), 7);
        chk("t4_mem_next", 32'(MEM_rd), 8);
        idle();
        tick();
        chk("t4_wb_next", 32'(WB_rd), 8);

        // 5: flush while frozen kills the next entrant
        set_in(1, 2, 1, 0, 0, 0, 0, 1, 1);
        tick();
        set_in(1, 9, 1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("t5_killed_rw", 32'(MEM_regwrite), 0);
        chk("t5_killed_rd", 32'(MEM_rd), 0);
        set_in(1, 10, 1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("t5_after_rw", 32'(MEM_regwrite), 1);
        chk("t5_after_rd", 32'(MEM_rd), 10);

        // 6: counters
        idle();
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 5, 1, 1, 1, 5, 1, 0, 0);
            tick();
            idle();
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
            tick();
        end
        idle();
        tick();
        chk("t6_scnt", stall_cnt, FEAT ? 32'd4 : 32'd0);
        chk("t6_mcnt", memstall_cnt, FEAT ? 32'd6 : 32'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            set_in(1'($urandom_range(0, 3) != 0),
                   5'($urandom_range(0, 7)),
                   1'($urandom),
                   1'($urandom),
                   1'($urandom_range(0, 3) != 0),
                   5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)),
                   1'($urandom_range(0, 6) == 0),
                   1'($urandom_range(0, 3) == 0));
            if (i % 150 == 149) begin
                do_reset();
            end
            tick();
        end
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
